// File: rtl/unet_host_sequencer.sv
// Host sequencer for the U-Net accelerator: weight load, input stream,
// calc wait and result drain into the result SRAM, with wait-state timeout.
module unet_host_sequencer #(
  parameter int N_WEIGHTS = 940,
  parameter int N_INPUT   = 49218,
  parameter int N_OUTPUT  = 65536,
  parameter int AW        = 17,
  parameter int TIMEOUT   = 1 << 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          load_weights,
  input  logic [2:0]    acc_ctrl,
  output logic          acc_enpulse,
  output logic [31:0]   acc_data_in,
  input  logic [31:0]   acc_data_out,
  output logic [AW-1:0] wmem_addr,
  input  logic [31:0]   wmem_rdata,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic          omem_we,
  output logic [AW-1:0] omem_addr,
  output logic [31:0]   omem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] LAST_W = AW'(N_WEIGHTS - 1);
  localparam logic [AW-1:0] LAST_I = AW'(N_INPUT - 1);
  localparam logic [AW-1:0] LAST_O = AW'(N_OUTPUT - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] C_SW   = 3'd1;
  localparam logic [2:0] C_SD   = 3'd2;
  localparam logic [2:0] C_RDY  = 3'd3;
  localparam logic [2:0] C_SND  = 3'd4;
  localparam logic [2:0] C_IDLE = 3'd5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ_W  = 3'd1;
  localparam logic [2:0] S_SEND_W = 3'd2;
  localparam logic [2:0] S_REQ_D  = 3'd3;
  localparam logic [2:0] S_SEND_D = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_RECV   = 3'd6;
  localparam logic [2:0] S_FIN    = 3'd7;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_inc;
  logic [AW-1:0] lim;
  logic [AW-1:0] ptr;
  logic [TW-1:0] timer;
  logic          enp_q;
  logic          enp_nx;
  logic          err_q;
  logic          acc_w;
  logic          acc_d;
  logic          acc_o;
  logic          accept;
  logic          last;
  logic          timed;
  logic          tmo;

  assign acc_w  = (state == S_SEND_W) && (acc_ctrl == C_SW);
  assign acc_d  = (state == S_SEND_D) && (acc_ctrl == C_SD);
  assign acc_o  = (state == S_RECV) && (acc_ctrl == C_SND);
  assign accept = acc_w | acc_d | acc_o;

  always_comb begin
    lim = '0;
    unique case (state)
      S_SEND_W: lim = LAST_W;
      S_SEND_D: lim = LAST_I;
      S_RECV:   lim = LAST_O;
      default:  lim = '0;
    endcase
  end

  assign last    = (cnt == lim);
  assign cnt_inc = last ? '0 : cnt + AW'(1);
  // Prefetch: on an accept the SRAM already fetches the next word
  assign ptr     = accept ? cnt_inc : cnt;

  always_comb begin
    state_nx = state;
    enp_nx   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = load_weights ? S_REQ_W : S_REQ_D;
      end
      S_REQ_W: begin
        if (acc_ctrl == C_IDLE) begin
          state_nx = S_SEND_W;
          enp_nx   = 1'b1;
        end
      end
      S_SEND_W: begin
        if (acc_w && last) state_nx = S_REQ_D;
      end
      S_REQ_D: begin
        if (acc_ctrl == C_IDLE) begin
          state_nx = S_SEND_D;
          enp_nx   = 1'b1;
        end
      end
      S_SEND_D: begin
        if (acc_d && last) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (acc_ctrl == C_RDY) begin
          state_nx = S_RECV;
          enp_nx   = 1'b1;
        end
      end
      S_RECV: begin
        if (acc_o && last) state_nx = S_FIN;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign timed = (state != S_IDLE) && (state != S_FIN);
  assign tmo   = timed && (state_nx == state) && !accept &&
                 (timer == T_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      timer <= '0;
      enp_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      enp_q <= enp_nx;
      if (tmo) begin
        state <= S_IDLE;
        err_q <= 1'b1;
        cnt   <= '0;
        timer <= '0;
      end else begin
        state <= state_nx;
        if (state == S_IDLE && start) err_q <= 1'b0;
        if (state_nx != state || accept) timer <= '0;
        else if (timed) timer <= timer + TW'(1);
        if (state == S_IDLE) cnt <= '0;
        else if (accept) cnt <= cnt_inc;
      end
    end
  end

  assign acc_enpulse = enp_q;
  assign acc_data_in = (state == S_SEND_W) ? wmem_rdata :
                       (state == S_SEND_D) ? imem_rdata : '0;
  assign wmem_addr   = (state == S_SEND_W) ? ptr : '0;
  assign imem_addr   = (state == S_SEND_D) ? ptr : '0;
  assign omem_we     = acc_o;
  assign omem_addr   = acc_o ? cnt : '0;
  assign omem_wdata  = acc_o ? acc_data_out : '0;
  assign busy        = timed;
  assign done        = (state == S_FIN);
  assign err         = err_q;

endmodule

// File: tb/tb_unet_host_sequencer.sv
// Bench for unet_host_sequencer: behavioural accelerator, SRAM models
// and a queue scoreboard checked whenever the DUT presents a word.
module tb_unet_host_sequencer;

  localparam int NW = 4;
  localparam int NI = 6;
  localparam int NO = 8;
  localparam int AW = 4;
  localparam logic [31:0] K = 32'h9E3779B9;

  localparam int M_IDLE  = 0;
  localparam int M_W     = 1;
  localparam int M_D     = 2;
  localparam int M_CALC  = 3;
  localparam int M_READY = 4;
  localparam int M_SEND  = 5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          load_weights;
  logic [2:0]    acc_ctrl;
  logic          acc_enpulse;
  logic [31:0]   acc_data_in;
  logic [31:0]   acc_data_out;
  logic [AW-1:0] wmem_addr;
  logic [31:0]   wmem_rdata;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          omem_we;
  logic [AW-1:0] omem_addr;
  logic [31:0]   omem_wdata;
  logic          busy;
  logic          done;
  logic          err;

  unet_host_sequencer #(
    .N_WEIGHTS(NW), .N_INPUT(NI), .N_OUTPUT(NO), .AW(AW), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_weights(load_weights),
    .acc_ctrl(acc_ctrl), .acc_enpulse(acc_enpulse),
    .acc_data_in(acc_data_in), .acc_data_out(acc_data_out),
    .wmem_addr(wmem_addr), .wmem_rdata(wmem_rdata),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .omem_we(omem_we), .omem_addr(omem_addr), .omem_wdata(omem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  logic [31:0] wmem [NW];
  logic [31:0] imem [NI];
  logic [31:0] omem [NO];
  logic [31:0] exp_o [NO];

  logic [31:0] exp_in [$];
  int          exp_oa [$];
  logic [31:0] exp_od [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_enp = 0;
  int n_done = 0;
  int last_acc_cyc = 0;

  bit run_lw, run_hang, run_stall, run_rand;
  int run_lat = 1;
  int abort_req = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  always @(posedge clk) begin
    wmem_rdata <= (wmem_addr < 4'd4) ? wmem[wmem_addr[1:0]] : 32'h0;
    imem_rdata <= (imem_addr < 4'd6) ? imem[imem_addr[2:0]] : 32'h0;
    if (omem_we && omem_addr < 4'd8) omem[omem_addr[2:0]] <= omem_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Behavioural accelerator
  initial begin : acc_model
    int mst, mk, mstall, mlat, aseen;
    bit mmid;
    logic [31:0] msum;
    mst = M_IDLE; mk = 0; mstall = 0; mlat = 0; aseen = 0;
    mmid = 0; msum = '0;
    acc_ctrl = 3'd5;
    acc_data_out = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || abort_req != aseen) begin
        aseen = abort_req;
        mst = M_IDLE; mstall = 0; mmid = 0; mk = 0;
      end else begin
        case (mst)
          M_IDLE: if (acc_enpulse) begin
            if (!mmid) begin
              mmid = 1; msum = '0;
              mst = run_lw ? M_W : M_D;
            end else mst = M_D;
            mk = 0;
          end
          M_W, M_D: begin
            if (mstall > 0) mstall--;
            else if (acc_ctrl == ((mst == M_W) ? 3'd1 : 3'd2)) begin
              msum += acc_data_in;
              mk++;
              if (mst == M_W && mk == NW) mst = M_IDLE;
              else if (mst == M_D && mk == NI) begin
                mst = M_CALC; mlat = run_lat;
              end else if (mst == M_D && run_stall && mk == 3) mstall = 3;
              else if (run_rand && $urandom_range(0, 3) == 0)
                mstall = $urandom_range(1, 3);
            end
          end
          M_CALC: if (!run_hang) begin
            if (mlat <= 1) mst = M_READY;
            else mlat--;
          end
          M_READY: if (acc_enpulse) begin
            mst = M_SEND; mk = 0;
          end
          default: begin
            if (mstall > 0) mstall--;
            else if (acc_ctrl == 3'd4) begin
              mk++;
              if (mk == NO) begin
                mst = M_IDLE; mmid = 0;
              end else if (run_rand && $urandom_range(0, 3) == 0)
                mstall = $urandom_range(1, 3);
            end
          end
        endcase
      end
      @(posedge clk);
      #1;
      case (mst)
        M_IDLE:  acc_ctrl = 3'd5;
        M_W:     acc_ctrl = (mstall > 0) ? 3'd0 : 3'd1;
        M_D:     acc_ctrl = (mstall > 0) ? 3'd0 : 3'd2;
        M_CALC:  acc_ctrl = 3'd0;
        M_READY: acc_ctrl = 3'd3;
        default: acc_ctrl = (mstall > 0) ? 3'd0 : 3'd4;
      endcase
      acc_data_out = (mst == M_SEND) ? msum + 32'(mk) * K : 32'h0;
    end
  end

  // Monitor: pops the scoreboard on every accepted word and every write
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (acc_enpulse) n_enp++;
      if (done) n_done++;
      if (acc_ctrl == 3'd1 || acc_ctrl == 3'd2) begin
        last_acc_cyc = cyc;
        if (exp_in.size() == 0) begin
          total++; bad++;
          $display("FAIL in_word: got %0h want none", acc_data_in);
        end else chk("in_word", 64'(acc_data_in), 64'(exp_in.pop_front()));
      end
      if (omem_we) begin
        if (exp_oa.size() == 0) begin
          total++; bad++;
          $display("FAIL out_write: got addr %0d want none", omem_addr);
        end else begin
          chk("out_addr", 64'(omem_addr), 64'(exp_oa.pop_front()));
          chk("out_data", 64'(omem_wdata), 64'(exp_od.pop_front()));
        end
      end
    end
  end

  // mode: 0 normal, 1 accelerator hangs, 2 reset mid-drain, 3 start poke
  task automatic do_run(input bit lw, input int mode, input bit stall,
                        input bit rnd);
    logic [31:0] s;
    int e0, d0;
    bit fin, rst_hit;
    s = '0;
    exp_in.delete(); exp_oa.delete(); exp_od.delete();
    for (int i = 0; i < NW; i++) wmem[i] = $urandom;
    for (int i = 0; i < NI; i++) imem[i] = $urandom;
    for (int i = 0; i < NO; i++) omem[i] = '0;
    if (lw) for (int i = 0; i < NW; i++) begin
      exp_in.push_back(wmem[i]); s += wmem[i];
    end
    for (int i = 0; i < NI; i++) begin
      exp_in.push_back(imem[i]); s += imem[i];
    end
    for (int k = 0; k < NO; k++) begin
      exp_o[k] = s + 32'(k) * K;
      if (mode != 1) begin
        exp_oa.push_back(k); exp_od.push_back(exp_o[k]);
      end
    end
    run_lw = lw; run_hang = (mode == 1); run_stall = stall;
    run_rand = rnd; run_lat = $urandom_range(1, 6);
    repeat (2) @(negedge clk);
    e0 = n_enp; d0 = n_done;
    start = 1'b1; load_weights = lw;
    @(negedge clk);
    start = 1'b0; load_weights = 1'($urandom);
    chk("busy_rise", 64'(busy), 64'd1);
    chk("err_clear", 64'(err), 64'd0);
    fin = 0; rst_hit = 0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      if (mode == 3 && i == 5) begin start = 1'b1; load_weights = !lw; end
      if (mode == 3 && i == 6) start = 1'b0;
      if (done) begin
        chk("busy_at_done", 64'(busy), 64'd0);
        fin = 1;
      end
      if (err) fin = 1;
      if (mode == 2 && omem_we && omem_addr == 4'd4) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ctl", 64'({acc_enpulse, wmem_addr, imem_addr, omem_we,
                            omem_addr, busy, done, err}), 64'd0);
        chk("rst_data", {acc_data_in, omem_wdata}, 64'd0);
        exp_in.delete(); exp_oa.delete(); exp_od.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fin = 1; rst_hit = 1;
      end
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL run_timeout: got no done/err want completion");
    end else if (mode == 1) begin
      chk("tmo_err", 64'(err), 64'd1);
      chk("tmo_busy", 64'(busy), 64'd0);
      chk("tmo_cycles", 64'(cyc - last_acc_cyc), 64'd17);
      repeat (2) @(negedge clk);
      chk("tmo_no_done", 64'(n_done - d0), 64'd0);
      chk("tmo_enp", 64'(n_enp - e0), lw ? 64'd2 : 64'd1);
      abort_req++;
    end else if (mode == 2) begin
      chk("rst_seen", 64'(rst_hit), 64'd1);
    end else begin
      repeat (2) @(negedge clk);
      chk("done_once", 64'(n_done - d0), 64'd1);
      chk("enp_count", 64'(n_enp - e0), lw ? 64'd3 : 64'd2);
      chk("err_low", 64'(err), 64'd0);
      chk("in_left", 64'(exp_in.size()), 64'd0);
      chk("out_left", 64'(exp_oa.size()), 64'd0);
      for (int k = 0; k < NO; k++) chk("omem", 64'(omem[k]), 64'(exp_o[k]));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; load_weights = 1'b0;
    #23;
    chk("reset_enp", 64'(acc_enpulse), 64'd0);
    chk("reset_din", 64'(acc_data_in), 64'd0);
    chk("reset_waddr", 64'(wmem_addr), 64'd0);
    chk("reset_iaddr", 64'(imem_addr), 64'd0);
    chk("reset_we", 64'(omem_we), 64'd0);
    chk("reset_oaddr", 64'(omem_addr), 64'd0);
    chk("reset_wdata", 64'(omem_wdata), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_run(1'b1, 0, 1'b0, 1'b0);
    do_run(1'b0, 0, 1'b0, 1'b0);
    do_run(1'b0, 0, 1'b1, 1'b0);
    do_run(1'b1, 1, 1'b0, 1'b0);
    do_run(1'b1, 0, 1'b0, 1'b0);
    do_run(1'b1, 2, 1'b0, 1'b0);
    do_run(1'b0, 0, 1'b0, 1'b0);
    do_run(1'b1, 3, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++) do_run(1'($urandom), 0, 1'b0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unet_host_sequencer.md
# unet_host_sequencer

Host-side sequencer that drives the U-Net accelerator FSM (`unet_fsm_3_1`) through one complete inference:
- optional weight load;
- input-layer streaming;
- wait for calculation;
- output drain into a result memory.

It sits between the system's weight/input SRAMs and result SRAM on one side and the accelerator's `ctrl`/`unet_enpulse`/`data_in`/`data_out` port on the other. It replaces testbench-driven sequencing in the integrated design.

## Interface
- N_WEIGHTS, 940: words sent while accelerator reports SEND_WEIGHTS
- N_INPUT, 49218: words sent while accelerator reports SEND_DATA
- N_OUTPUT, 65536: words captured while accelerator reports SENDING
- AW, 17: address/counter width (must hold max(N)–1)
- TIMEOUT, 2^20: cycles allowed in any wait state before error
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle run request; ignored unless busy=0
- load_weights  in  1  sampled with start; 1 = send weights this run
- acc_ctrl  in  3  accelerator status: 0 CALCULATING, 1 SEND_WEIGHTS, 2 SEND_DATA, 3 DATA_READY, 4 SENDING, 5 IDLE
- acc_enpulse  out  1  registered one-cycle request pulse to accelerator
- acc_data_in  out  32  word to accelerator (= selected memory rdata)
- acc_data_out  in  32  result word from accelerator
- wmem_addr  out  AW  weight SRAM address (sync read, 1-cycle latency)
- wmem_rdata  in  32  weight SRAM data
- imem_addr  out  AW  input SRAM address (sync read, 1-cycle latency)
- imem_rdata  in  32  input SRAM data
- omem_we  out  1  result SRAM write enable
- omem_addr  out  AW  result SRAM address
- omem_wdata  out  32  result SRAM data
- busy  out  1  run in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky timeout flag; cleared by next accepted start

## Operation
- States: IDLE, REQ_W, SEND_W, REQ_D, SEND_D, WAIT_CALC, RECV, FINISH.
- IDLE: on start, latch load_weights, clear err/cnt/timer, go to REQ_W if weights requested, else REQ_D.
- REQ_W / REQ_D: wait for acc_ctrl==5; on that cycle register acc_enpulse=1 and go to SEND_W / SEND_D.
- SEND_W / SEND_D, transfer rules:
  - accept = (acc_ctrl==1 resp. 2); each accept cycle consumes acc_data_in and increments cnt.
  - acc_ctrl other than the expected code stalls cnt (no word lost).
  - Accept at cnt==N–1 clears cnt and goes to REQ_D (from SEND_W) or WAIT_CALC (from SEND_D).
- Address prefetch, so rdata always equals mem[cnt]:
  - mem_addr = accept ? cnt+1 : cnt, combinational.
  - acc_data_in = wmem_rdata in SEND_W, imem_rdata in SEND_D, 0 otherwise.
  - Unselected memory address holds 0.
- WAIT_CALC: wait for acc_ctrl==3; pulse acc_enpulse, go to RECV.
- RECV: each cycle with acc_ctrl==4:
  - drive omem_we=1, omem_addr=cnt, omem_wdata=acc_data_out; increment cnt.
  - the write at cnt==N_OUTPUT–1 goes to FINISH.
- FINISH: done=1 for one cycle, busy drops, return to IDLE.
- Timeout:
  - timer counts every cycle in REQ_*, WAIT_CALC, and stalled SEND_*/RECV; cleared on every state change or accept.
  - On reaching TIMEOUT: err=1, busy=0, no done, return to IDLE.
- Reset (any time, incl. mid-stream): state IDLE, cnt/timer 0.
  - All outputs 0: acc_enpulse, acc_data_in, addresses, omem_*, busy, done, err.
  - Partial result memory contents undefined.

## Timing
- acc_enpulse asserts the cycle after acc_ctrl==5 is sampled in REQ_*; exactly one cycle wide.
- busy rises the cycle after start is accepted and falls the cycle done (or err) asserts.
- Streaming at full rate: one word per clk while acc_ctrl holds the send code; no bubbles.
- First word is valid because the state holds ≥1 cycle with addr=0 before the first accept (REQ_* cycle).
- omem write is same-cycle with the sampled acc_data_out (no pipeline).
- start during busy: ignored, no effect on state or err.
- Minimal run, no weights: N_INPUT + N_OUTPUT + accelerator latency + ~4 control cycles.

## Test plan
- Small params (N_WEIGHTS=4, N_INPUT=6, N_OUTPUT=8); behavioural accelerator model. start with load_weights=1:
  - acc_enpulse seen exactly twice before data, once before drain.
  - Model receives W[0..3] and I[0..5] in order.
  - omem holds 8 model outputs at addresses 0..7.
  - done pulses once.
- load_weights=0 → no SEND_W phase; first enpulse leads directly to SEND_D; single enpulse before data phase.
- Model drops acc_ctrl to 0 for 3 cycles mid SEND_D after word 2 → next accepted word is I[3], no duplicate or skip.
- TIMEOUT=16, model never leaves CALCULATING → err=1 after 16 cycles in WAIT_CALC, busy=0, no done; a new start clears err.
- rst_n low during RECV at cnt=5 → all outputs 0 immediately; fresh start runs to correct completion.
- start pulsed while busy → ignored: sequence and omem contents identical to an undisturbed run.
